// File: rtl/neuron_mac_if.sv
// Handshake bundle for neuron_mac: start/bias request, pixel/weight stream in,
// saturated result out.
interface neuron_mac_if #(
  parameter int DATA_W = 16
);
  logic                     start;
  logic signed [DATA_W-1:0] bias;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] pixel;
  logic signed [DATA_W-1:0] weight;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     ovf;
  logic                     busy;

  modport master (
    output start, bias, in_valid, pixel, weight, out_ready,
    input  in_ready, out_valid, out_data, ovf, busy
  );

  modport slave (
    input  start, bias, in_valid, pixel, weight, out_ready,
    output in_ready, out_valid, out_data, ovf, busy
  );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: sum of pixel*weight over N_INPUTS pairs plus
// bias, in Q8.8 with a one-stage product pipeline and saturating output.
module neuron_mac #(
  parameter int DATA_W   = 16,
  parameter int N_INPUTS = 784,
  parameter int ACC_W    = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  neuron_mac_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, SAT, OUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_vld_q, prod_vld_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     ovf_q, ovf_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic                     accept;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  shifted;

  assign accept   = bus.in_valid & in_ready_q & ce;
  assign prod_ext = ACC_W'(prod_q);
  assign bias_ext = ACC_W'(bias_q) <<< 8;
  assign shifted  = acc_q >>> 8;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_vld_d  = prod_vld_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bias_d     = bus.bias;
          acc_d      = '0;
          cnt_d      = '0;
          prod_vld_d = 1'b0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        // The product registered last cycle is folded in while the next one is formed.
        if (prod_vld_q) acc_d = acc_q + prod_ext;
        if (accept) begin
          prod_d     = PROD_W'(bus.pixel) * PROD_W'(bus.weight);
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
            in_ready_d = 1'b0;
            state_d    = DRAIN;
          end
        end else begin
          prod_vld_d = 1'b0;
        end
      end
      DRAIN: begin
        if (prod_vld_q) acc_d = acc_q + prod_ext;
        prod_vld_d = 1'b0;
        state_d    = BIAS;
      end
      BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = SAT;
      end
      SAT: begin
        if (shifted > SAT_MAX) begin
          out_data_d = SAT_MAX[DATA_W-1:0];
          ovf_d      = 1'b1;
        end else if (shifted < SAT_MIN) begin
          out_data_d = SAT_MIN[DATA_W-1:0];
          ovf_d      = 1'b1;
        end else begin
          out_data_d = shifted[DATA_W-1:0];
          ovf_d      = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        // First OUT cycle raises out_valid; the handshake completes only once it is visible.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      bias_q      <= '0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed and randomized checks of neuron_mac (N_INPUTS=4) against an
// arithmetic reference model of the neuron sum.
module tb_neuron_mac;
  localparam int DW = 16;
  localparam int NI = 4;
  localparam int AW = 48;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  neuron_mac_if #(.DATA_W(DW)) bus ();

  neuron_mac #(.DATA_W(DW), .N_INPUTS(NI), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] px[NI];
  logic [DW-1:0] wt[NI];
  logic [6:0] gap_pat = 7'b1011001;  // cycle 0..6 valid = 1,0,0,1,1,0,1

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum in Q16.16, floor to Q8.8, clip to 16-bit signed.
  task automatic model(input logic [DW-1:0] b, output logic [DW-1:0] res, output logic o);
    longint s;
    s = 0;
    for (int i = 0; i < NI; i++)
      s += longint'($signed(px[i])) * longint'($signed(wt[i]));
    s += longint'($signed(b)) * 256;
    s = s >>> 8;
    if (s > 32767) begin
      res = 16'h7FFF; o = 1'b1;
    end else if (s < -32768) begin
      res = 16'h8000; o = 1'b1;
    end else begin
      res = s[15:0]; o = 1'b0;
    end
  endtask

  task automatic set_pairs(input logic [DW-1:0] p, input logic [DW-1:0] w);
    for (int i = 0; i < NI; i++) begin
      px[i] = p;
      wt[i] = w;
    end
  endtask

  // gap_pct < 0 selects the fixed valid pattern; otherwise random gaps.
  task automatic run_eval(input string nm, input logic [DW-1:0] b, input int gap_pct,
                          input int bp, input bit ce_gap, input bit start_glitch);
    logic [DW-1:0] er;
    logic          eo;
    logic [DW-1:0] hold;
    bit            stable;
    bit            acc;
    int            sent;
    int            cyc;
    int            lat;
    model(b, er, eo);
    sent = 0;
    cyc  = 0;
    bus.bias  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bias  = '0;
    chk({nm, ":in_ready"}, 16'(bus.in_ready), 16'd1);
    while (sent < NI && cyc < 100) begin
      if (gap_pct < 0) bus.in_valid = (cyc < 7) ? gap_pat[cyc] : 1'b1;
      else bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
      ce = !(ce_gap && (cyc == 3 || cyc == 4));
      bus.start  = start_glitch && (cyc == 1);
      bus.pixel  = px[sent];
      bus.weight = wt[sent];
      acc = bus.in_valid && bus.in_ready && ce;
      tick();
      if (acc) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    ce           = 1'b1;
    chk({nm, ":accepted"}, 16'(sent), 16'(NI));
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, ":latency"}, 16'(lat), 16'd4);
    chk({nm, ":out_data"}, bus.out_data, er);
    chk({nm, ":ovf"}, 16'(bus.ovf), 16'(eo));
    hold   = bus.out_data;
    stable = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (bus.out_data !== hold || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    if (bp > 0) chk({nm, ":hold_stable"}, 16'(stable), 16'd1);
    bus.out_ready = 1'b1;
    bus.start     = start_glitch;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk({nm, ":out_valid_after"}, 16'(bus.out_valid), 16'd0);
    chk({nm, ":busy_after"}, 16'(bus.busy), 16'd0);
    $display("eval %s bias=%h result=%h ovf=%b expected=%h/%b", nm, b, bus.out_data, bus.ovf, er, eo);
  endtask

  initial begin
    int sent;
    int cyc;
    rst = 1'b1;
    ce  = 1'b1;
    bus.start = 1'b0; bus.bias = '0; bus.in_valid = 1'b0;
    bus.pixel = '0; bus.weight = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    chk("reset:busy", 16'(bus.busy), 16'd0);
    chk("reset:out_valid", 16'(bus.out_valid), 16'd0);
    chk("reset:in_ready", 16'(bus.in_ready), 16'd0);
    chk("reset:out_data", bus.out_data, 16'h0000);
    chk("reset:ovf", 16'(bus.ovf), 16'd0);
    rst = 1'b0;
    tick();
    chk("idle:busy", 16'(bus.busy), 16'd0);

    set_pairs(16'h0100, 16'h0200);
    run_eval("nominal", 16'h0080, 0, 0, 1'b0, 1'b0);
    set_pairs(16'h0100, 16'hFF00);
    run_eval("negative", 16'h0000, 0, 0, 1'b0, 1'b0);
    set_pairs(16'h7FFF, 16'h7FFF);
    run_eval("sat_pos", 16'h0000, 0, 0, 1'b0, 1'b0);
    set_pairs(16'h7FFF, 16'h8000);
    run_eval("sat_neg", 16'h0000, 0, 0, 1'b0, 1'b0);
    set_pairs(16'h0100, 16'h0200);
    run_eval("gaps_bp", 16'h0080, -1, 3, 1'b1, 1'b0);

    // Reset in the middle of accumulation.
    set_pairs(16'h0100, 16'h0200);
    bus.bias = 16'h0080; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    sent = 0; cyc = 0;
    while (sent < 2 && cyc < 20) begin
      bus.in_valid = 1'b1; bus.pixel = px[sent]; bus.weight = wt[sent];
      if (bus.in_ready) begin
        tick(); sent++;
      end else begin
        tick();
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("midrst:busy_before", 16'(bus.busy), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst:busy", 16'(bus.busy), 16'd0);
    chk("midrst:out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrst:in_ready", 16'(bus.in_ready), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    run_eval("after_rst", 16'h0080, 0, 0, 1'b0, 1'b0);

    run_eval("ign_start", 16'h0080, 0, 1, 1'b0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NI; i++) begin
        px[i] = 16'($urandom);
        wt[i] = (k < 4) ? 16'($signed(16'($urandom)) >>> 6) : 16'($urandom);
      end
      run_eval($sformatf("rand%0d", k), 16'($urandom), 30, int'($urandom_range(3)), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
Parameters:
REQ-001 The block SHALL provide parameter DATA_W, default 16, the width of the signed Q8.8 pixel, weight, bias and result words.
REQ-002 The block SHALL provide parameter N_INPUTS, default 784, the number of pixel/weight pairs per neuron evaluation (28x28 image).
REQ-003 The block SHALL provide parameter ACC_W, default 48, the signed accumulator width in Q(ACC_W-16).16.

Ports:
REQ-004 The block SHALL have the following ports, and the clock SHALL be named clk and the reset rst, with one clock and an asynchronous, active-high reset:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; low freezes all state and registered outputs.
- start  in  1  single-cycle request to begin a neuron evaluation.
- bias  in  DATA_W  signed Q8.8 bias, sampled at start.
- in_valid  in  1  pixel/weight pair present.
- in_ready  out  1  pair accepted when in_valid & in_ready & ce.
- pixel  in  DATA_W  signed Q8.8 activation.
- weight  in  DATA_W  signed Q8.8 weight.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed Q8.8 saturated neuron sum.
- ovf  out  1  result was clipped; valid with out_valid.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, ACCUM, DRAIN, BIAS, SAT and OUT.
REQ-006 In IDLE, start & ce SHALL latch bias, clear acc, clear the input counter and move to ACCUM; start SHALL be ignored in every other state.
REQ-007 in_ready SHALL be high only in ACCUM.
- Each accepted pair registers the full-precision signed product pixel*weight (2*DATA_W bits, Q16.16) into a one-stage product register.
- The previous product register content is added, sign-extended to ACC_W, into acc.
REQ-008 The counter SHALL increment per accepted pair; on acceptance of pair N_INPUTS the FSM SHALL move to DRAIN.
REQ-009 in_valid gaps SHALL NOT add stale products; the product register SHALL carry a valid flag and only flagged products SHALL be accumulated.
REQ-010 DRAIN SHALL accumulate the last flagged product and move to BIAS.
REQ-011 BIAS SHALL add the latched bias, sign-extended and shifted left 8 (Q8.8 to Q16.16), to acc and move to SAT.
REQ-012 SAT SHALL arithmetic-shift acc right 8 (truncation toward minus infinity) and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- The result is registered into out_data.
- ovf is set if clipping occurred.
- The FSM then moves to OUT.
REQ-013 In OUT, out_valid SHALL be high, and out_data and ovf SHALL be held stable until out_valid & out_ready & ce, after which the FSM SHALL return to IDLE with out_valid low on the next cycle.
REQ-014 With ce held high, out_valid SHALL rise exactly 4 rising edges after the edge that accepts pair N_INPUTS (DRAIN, BIAS, SAT, OUT).
REQ-015 When ce is low, no state, counter, acc, product or output register SHALL change, and no handshake SHALL complete.
REQ-016 ACC_W SHALL be wide enough that N_INPUTS products of full-scale magnitude do not wrap; the default of 48 bits covers 784 x 2^30.
REQ-017 start asserted in the same cycle as the OUT-to-IDLE transition SHALL be ignored; start is honoured only when sampled in IDLE.

Reset
REQ-018 Asserting rst SHALL immediately, without a clock, force state IDLE; acc, counter, product register and flag, latched bias, out_data, ovf, out_valid and busy to 0; and in_ready to 0.
REQ-019 rst asserted mid-operation in any state SHALL abandon the evaluation with no partial result emitted.
REQ-020 Deassertion of rst SHALL leave the block in IDLE awaiting start.

Verification (N_INPUTS=4 override)
REQ-021 Nominal: start with bias=0x0080, then 4 pairs pixel=0x0100 and weight=0x0200 back-to-back -> out_data=0x0880, ovf=0, out_valid 4 edges after the 4th accept.
REQ-022 Negative: bias=0x0000, 4 pairs pixel=0x0100 and weight=0xFF00 -> out_data=0xFC00, ovf=0.
REQ-023 Saturation: 4 pairs pixel=0x7FFF and weight=0x7FFF -> out_data=0x7FFF, ovf=1; 4 pairs pixel=0x7FFF and weight=0x8000 -> out_data=0x8000, ovf=1.
REQ-024 Backpressure/gaps: in_valid toggles 1,0,0,1,1,0,1 with ce low for 2 cycles mid-stream, and out_ready is held low for 3 cycles in OUT -> result identical to REQ-021, and out_data is stable while out_ready is low.
REQ-025 Reset mid-run: rst pulsed after 2 accepted pairs -> busy=0 and out_valid=0 at once; a fresh start followed by the REQ-021 stimulus -> 0x0880.
REQ-026 Ignored start: start pulsed during ACCUM and in OUT -> no restart; the counter and result are unaffected.
